// File: rtl/bp_stream_pump_out.sv
// Transmit-side stream pump: turns one-beat-at-a-time FSM requests into a BedRock
// memory stream with a two-entry output buffer, critical-word-first beat counting and last generation.

module bp_stream_pump_out_chk
  #(parameter int hdr_width_p   = 54
  , parameter int align_width_p = 3
  )
  (input  logic                     clk_i
  , input logic                     reset_n_i
  , input logic                     streaming_i
  , input logic [hdr_width_p-1:0]   header_i
  , input logic                     multi_v_i
  , input logic [align_width_p-1:0] align_i
  );

  // The header must not change while a multi-beat message is in flight
  a_hdr_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    streaming_i |-> $stable(header_i));

  // Multi-beat messages must start on a stream-word boundary
  a_addr_align: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    multi_v_i |-> (align_i == {align_width_p{1'b0}}));

endmodule

module bp_stream_pump_out
  #(parameter int paddr_width_p        = 40
  , parameter int lce_id_width_p       = 4
  , parameter int lce_assoc_p          = 8
  , parameter int stream_data_width_p  = 64
  , parameter int block_width_p        = 512
  , parameter logic [15:0] payload_mask_p = 16'h0000
  , localparam int stream_words_lp     = block_width_p / stream_data_width_p
  , localparam int data_len_width_lp   = (stream_words_lp > 1) ? $clog2(stream_words_lp) : 1
  , localparam int xce_mem_msg_header_width_lp =
      lce_id_width_p + $clog2(lce_assoc_p) + 4 + 3 + paddr_width_p
  )
  (input  logic                                   clk_i
  , input  logic                                  reset_n_i
  , input  logic [xce_mem_msg_header_width_lp-1:0] fsm_base_header_i
  , input  logic [stream_data_width_p-1:0]         fsm_data_i
  , input  logic                                  fsm_v_i
  , output logic                                  fsm_ready_and_o
  , output logic [data_len_width_lp-1:0]          fsm_cnt_o
  , output logic                                  fsm_new_o
  , output logic                                  fsm_done_o
  , output logic [xce_mem_msg_header_width_lp-1:0] mem_header_o
  , output logic [stream_data_width_p-1:0]         mem_data_o
  , output logic                                  mem_v_o
  , output logic                                  mem_last_o
  , input  logic                                  mem_ready_and_i
  );

  // Header layout, LSB first: addr, size (log2 bytes), msg_type, payload
  localparam int stream_offset_lp = $clog2(stream_data_width_p / 8);
  localparam int size_lsb_lp      = paddr_width_p;
  localparam int msg_type_lsb_lp  = paddr_width_p + 3;
  localparam int entry_width_lp   = 1 + xce_mem_msg_header_width_lp + stream_data_width_p;

  typedef logic [data_len_width_lp:0]   beats_t;
  typedef logic [data_len_width_lp-1:0] cnt_t;

  function automatic beats_t calc_beats(input logic [2:0] size, input logic has_data);
    int words;
    words = 32'sd1;
    if (has_data && (int'(size) > stream_offset_lp)) begin
      words = 32'sd1 << (int'(size) - stream_offset_lp);
    end
    else begin
      words = 32'sd1;
    end
    if (words > stream_words_lp) begin
      words = stream_words_lp;
    end
    else begin
      words = words;
    end
    return beats_t'(words);
  endfunction

  logic [2:0] size_s;
  logic [3:0] msg_type_s;
  cnt_t       first_cnt_s;
  beats_t     beats_s;
  logic       multi_s;
  logic       accept_s;
  logic       last_s;
  logic       new_s;
  logic       streaming_s;
  cnt_t       cnt_s;
  logic       ready_en_r;

  assign size_s      = fsm_base_header_i[size_lsb_lp+:3];
  assign msg_type_s  = fsm_base_header_i[msg_type_lsb_lp+:4];
  assign first_cnt_s = fsm_base_header_i[stream_offset_lp+:data_len_width_lp];
  assign beats_s     = calc_beats(size_s, payload_mask_p[msg_type_s]);
  assign multi_s     = (beats_s > beats_t'(1'b1));

  // Two-entry output buffer of {last, header, data}
  logic [entry_width_lp-1:0] fifo_mem_r [2];
  logic                      wr_ptr_r;
  logic                      rd_ptr_r;
  logic [1:0]                count_r;
  logic                      deq_s;
  logic                      entry_last_s;

  assign fsm_ready_and_o = ready_en_r & (count_r != 2'd2);
  assign accept_s        = fsm_v_i & fsm_ready_and_o;
  assign mem_v_o         = (count_r != 2'd0);
  assign deq_s           = mem_v_o & mem_ready_and_i;
  assign {entry_last_s, mem_header_o, mem_data_o} = fifo_mem_r[rd_ptr_r];
  // A stale entry must not show last while the buffer is empty
  assign mem_last_o      = mem_v_o & entry_last_s;

  // Ready is held low during reset and for the first cycle after it
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ready_en_r <= 1'b0;
    end
    else begin
      ready_en_r <= 1'b1;
    end
  end

  // Buffer pointers and occupancy
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end
    else begin
      if (accept_s) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (deq_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, accept_s} - {1'b0, deq_s};
    end
  end

  // Buffer storage; contents are qualified by count_r so no reset is needed
  always_ff @(posedge clk_i) begin
    if (accept_s) begin
      fifo_mem_r[wr_ptr_r] <= {last_s, fsm_base_header_i, fsm_data_i};
    end
  end

  if (stream_words_lp > 1) begin : g_multi
    typedef enum logic {e_idle, e_stream} state_e;

    state_e state_r, state_n;
    cnt_t   cnt_r, cnt_n;
    beats_t beat_r, beat_n;

    // Beat counter and message-phase state
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        state_r <= e_idle;
        cnt_r   <= cnt_t'(1'b0);
        beat_r  <= beats_t'(1'b0);
      end
      else begin
        state_r <= state_n;
        cnt_r   <= cnt_n;
        beat_r  <= beat_n;
      end
    end

    // Next-state, word index and first/last decode
    always_comb begin
      state_n = state_r;
      cnt_n   = cnt_r;
      beat_n  = beat_r;
      cnt_s   = cnt_r;
      last_s  = 1'b0;
      new_s   = 1'b0;
      case (state_r)
        e_idle: begin
          cnt_s  = first_cnt_s;
          last_s = ~multi_s;
          if (accept_s && multi_s) begin
            new_s   = 1'b1;
            state_n = e_stream;
            cnt_n   = first_cnt_s + cnt_t'(1'b1);
            beat_n  = beats_t'(1'b1);
          end
          else begin
            state_n = e_idle;
          end
        end
        e_stream: begin
          last_s = (beat_r == (beats_s - beats_t'(1'b1)));
          if (accept_s) begin
            cnt_n  = cnt_r + cnt_t'(1'b1);
            beat_n = beat_r + beats_t'(1'b1);
            if (last_s) begin
              state_n = e_idle;
            end
            else begin
              state_n = e_stream;
            end
          end
          else begin
            state_n = e_stream;
          end
        end
        default: begin
          state_n = e_idle;
        end
      endcase
    end

    assign streaming_s = (state_r == e_stream);
  end
  else begin : g_single
    assign last_s      = 1'b1;
    assign new_s       = 1'b0;
    assign cnt_s       = cnt_t'(1'b0);
    assign streaming_s = 1'b0;
  end

  assign fsm_cnt_o  = ready_en_r ? cnt_s : cnt_t'(1'b0);
  assign fsm_new_o  = accept_s & new_s;
  assign fsm_done_o = accept_s & last_s;

  bp_stream_pump_out_chk
    #(.hdr_width_p(xce_mem_msg_header_width_lp)
    , .align_width_p(stream_offset_lp)
    )
    chk
    (.clk_i       (clk_i)
    , .reset_n_i  (reset_n_i)
    , .streaming_i(streaming_s)
    , .header_i   (fsm_base_header_i)
    , .multi_v_i  (fsm_v_i & multi_s)
    , .align_i    (fsm_base_header_i[stream_offset_lp-1:0])
    );

endmodule

// File: tb/tb_bp_stream_pump_out.sv
// Bench for bp_stream_pump_out: directed scenarios plus random messages and random bus
// backpressure, checked against a message-level beat model.

module tb_bp_stream_pump_out;

  localparam int AW    = 40;
  localparam int HW    = 54;
  localparam int DW    = 64;
  localparam int WORDS = 8;
  localparam logic [15:0] MASK = 16'h000A;

  typedef struct packed {
    logic          last;
    logic [HW-1:0] hdr;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic [HW-1:0] fsm_base_header_i;
  logic [DW-1:0] fsm_data_i;
  logic          fsm_v_i;
  logic          fsm_ready_and_o;
  logic [2:0]    fsm_cnt_o;
  logic          fsm_new_o;
  logic          fsm_done_o;
  logic [HW-1:0] mem_header_o;
  logic [DW-1:0] mem_data_o;
  logic          mem_v_o;
  logic          mem_last_o;
  logic          mem_ready_and_i;

  bp_stream_pump_out #(.payload_mask_p(MASK)) dut
    (.clk_i            (clk_i)
    , .reset_n_i        (reset_n_i)
    , .fsm_base_header_i(fsm_base_header_i)
    , .fsm_data_i       (fsm_data_i)
    , .fsm_v_i          (fsm_v_i)
    , .fsm_ready_and_o  (fsm_ready_and_o)
    , .fsm_cnt_o        (fsm_cnt_o)
    , .fsm_new_o        (fsm_new_o)
    , .fsm_done_o       (fsm_done_o)
    , .mem_header_o     (mem_header_o)
    , .mem_data_o       (mem_data_o)
    , .mem_v_o          (mem_v_o)
    , .mem_last_o       (mem_last_o)
    , .mem_ready_and_i  (mem_ready_and_i)
    );

  always #5 clk_i = ~clk_i;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    rdy_mode = 0;
  logic  saw_stall = 1'b0;
  beat_t exp_q[$];
  int    pop_cyc[$];
  logic  rdy_pat[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus-side monitor: drives ready and compares every transferred beat with the model
  initial begin
    beat_t e;
    mem_ready_and_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (rdy_pat.size() != 0) mem_ready_and_i = rdy_pat.pop_front();
      else if (rdy_mode == 1) mem_ready_and_i = 1'($urandom_range(0, 1));
      else mem_ready_and_i = 1'b1;
      #1;
      if (reset_n_i && mem_v_o && mem_ready_and_i) begin
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check_val("unexpected_beat", 64'(mem_data_o), 64'hDEAD);
        end
        else begin
          e = exp_q.pop_front();
          check_val("mem_data", mem_data_o, e.data);
          check_val("mem_header", 64'(mem_header_o), 64'(e.hdr));
          check_val("mem_last", 64'(mem_last_o), 64'(e.last));
        end
      end
    end
  end

  // Sends one message (or only its first 'limit' beats); checks FSM-side outputs per beat
  task automatic send_msg(input logic [AW-1:0] addr, input logic [2:0] size,
                          input logic [3:0] typ, input int limit, output int acc_cyc);
    logic [HW-1:0] hdr;
    logic [DW-1:0] d;
    int beats, first, n, g;
    hdr   = {7'($urandom), typ, size, addr};
    beats = 1;
    if (MASK[typ]) begin
      beats = (1 << size) / (DW / 8);
      if (beats < 1) beats = 1;
      if (beats > WORDS) beats = WORDS;
    end
    first   = int'((addr / (DW / 8)) % WORDS);
    n       = (limit > 0 && limit < beats) ? limit : beats;
    acc_cyc = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      fsm_base_header_i = hdr;
      d = {$urandom, $urandom};
      fsm_data_i = d;
      fsm_v_i = 1'b1;
      #1;
      g = 0;
      while (!fsm_ready_and_o && g < 64) begin
        saw_stall = 1'b1;
        @(negedge clk_i);
        #1;
        g++;
      end
      if (!fsm_ready_and_o) begin
        check_val("ready_timeout", 64'(fsm_ready_and_o), 64'd1);
        break;
      end
      check_val("fsm_cnt", 64'(fsm_cnt_o), 64'((first + i) % WORDS));
      check_val("fsm_new", 64'(fsm_new_o), 64'(i == 0 && beats > 1));
      check_val("fsm_done", 64'(fsm_done_o), 64'(i == beats - 1));
      if (i == 0) acc_cyc = cyc;
      exp_q.push_back(beat_t'{last: 1'(i == beats - 1), hdr: hdr, data: d});
      @(posedge clk_i);
    end
  endtask

  task automatic go_idle();
    @(negedge clk_i);
    fsm_v_i = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk_i);
      #2;
      g++;
    end
    check_val("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [AW-1:0] raddr;
    reset_n_i = 1'b0;
    fsm_v_i = 1'b0;
    fsm_base_header_i = '0;
    fsm_data_i = '0;
    repeat (2) @(negedge clk_i);
    #1;
    check_val("rst_mem_v", 64'(mem_v_o), 64'd0);
    check_val("rst_mem_last", 64'(mem_last_o), 64'd0);
    check_val("rst_ready", 64'(fsm_ready_and_o), 64'd0);
    check_val("rst_cnt", 64'(fsm_cnt_o), 64'd0);
    check_val("rst_new", 64'(fsm_new_o), 64'd0);
    check_val("rst_done", 64'(fsm_done_o), 64'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    // Full block, back-to-back, 1-cycle latency, no bubbles
    pop_cyc.delete();
    send_msg(40'h1000, 3'd6, 4'd1, 0, acc);
    go_idle();
    drain();
    check_val("full_pop_count", 64'(pop_cyc.size()), 64'd8);
    check_val("full_latency", 64'(pop_cyc[0]), 64'(acc + 1));
    check_val("full_throughput", 64'(pop_cyc[7]), 64'(pop_cyc[0] + 7));

    // Critical-word wrap, read without payload, backpressure
    send_msg(40'h1028, 3'd6, 4'd1, 0, acc);
    send_msg(40'h1000, 3'd6, 4'd0, 0, acc);
    go_idle();
    drain();
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    saw_stall = 1'b0;
    send_msg(40'h2000, 3'd5, 4'd1, 0, acc);
    go_idle();
    drain();
    check_val("bp_stall_seen", 64'(saw_stall), 64'd1);

    // Uncached 8B write immediately followed by a 16B write
    send_msg(40'h3008, 3'd3, 4'd3, 0, acc);
    send_msg(40'h0018, 3'd4, 4'd1, 0, acc);
    go_idle();
    drain();

    // Reset in the middle of an 8-beat message
    send_msg(40'h1010, 3'd6, 4'd1, 3, acc);
    @(negedge clk_i);
    fsm_v_i = 1'b0;
    reset_n_i = 1'b0;
    #1;
    check_val("midrst_mem_v", 64'(mem_v_o), 64'd0);
    check_val("midrst_ready", 64'(fsm_ready_and_o), 64'd0);
    check_val("midrst_cnt", 64'(fsm_cnt_o), 64'd0);
    exp_q.delete();
    @(negedge clk_i);
    reset_n_i = 1'b1;
    send_msg(40'h1018, 3'd6, 4'd1, 0, acc);
    go_idle();
    drain();

    // Random messages with random bus backpressure
    rdy_mode = 1;
    repeat (40) begin
      raddr = {8'h00, $urandom} & ~40'h7;
      send_msg(raddr, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)), 0, acc);
    end
    go_idle();
    drain();
    rdy_mode = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
